pipe_stage_buf: RTL

//  Generic pipeline stage register with a valid/allowin handshake, replacing the hand-written
//  per-stage latches (e.g. EX->MEM). The payload is one flat vector of width DW.

---
 rtl/pipe_stage_buf.sv | 96 +++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/allowin handshake, multi-cycle ready_go,
// synchronous flush, optional skid entry and a saturating stall counter.
module pipe_stage_buf #(
  parameter int DW    = 160,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             allowin,
  input  logic             ready_go,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             next_allowin,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          head_valid;
  logic          skid_valid;
  logic [DW-1:0] head_data;
  logic          push;
  logic          pop;

  assign out_valid = head_valid & ready_go & ~flush;
  assign out_data  = head_data;
  assign push      = in_valid & allowin & ~flush;
  assign pop       = out_valid & next_allowin;
  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

  generate
    if (SKID == 0) begin : g_single
      assign allowin    = ~head_valid | (ready_go & next_allowin);
      assign skid_valid = 1'b0;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          head_valid <= 1'b0;
          head_data  <= '0;
        end else if (flush) begin
          head_valid <= 1'b0;
        end else if (allowin) begin
          head_valid <= in_valid;
          if (push) head_data <= in_data;
        end
      end
    end else begin : g_skid
      logic [DW-1:0] skid_data;

      // allowin comes from a flop only, breaking the next_allowin -> allowin chain
      assign allowin = ~skid_valid;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
          head_data  <= '0;
          skid_data  <= '0;
        end else if (flush) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (pop) begin
          if (skid_valid) begin
            head_data  <= skid_data;
            skid_valid <= 1'b0;
          end else if (push) begin
            head_data  <= in_data;
          end else begin
            head_valid <= 1'b0;
          end
        end else if (push) begin
          if (!head_valid) begin
            head_valid <= 1'b1;
            head_data  <= in_data;
          end else begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
          end
        end
      end
    end
  endgenerate

  logic stall;
  assign stall = head_valid & ~(ready_go & next_allowin) & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn || cnt_clr) stall_cnt <= '0;
    else if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
